// File: rtl/ssd_pkg.sv
// ssd_pkg: display codes and segment constants shared by the scan driver and the lock FSM
package ssd_pkg;
  typedef logic [4:0] ssd_code_t;
  localparam ssd_code_t SSD_BLANK = 5'h10;
  localparam ssd_code_t SSD_C = 5'h11;
  localparam ssd_code_t SSD_L = 5'h12;
  localparam ssd_code_t SSD_TIRE = 5'h13;
  localparam ssd_code_t SSD_P = 5'h14;
  localparam ssd_code_t SSD_E = 5'h15;
  localparam ssd_code_t SSD_N = 5'h16;
  localparam ssd_code_t SSD_U = 5'h17;
  localparam ssd_code_t SSD_O = 5'h18;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
endpackage

// File: rtl/ssd_scan_if.sv
// ssd_scan_if: display word, masks and pin outputs between the lock FSM side and the scan driver
interface ssd_scan_if;
  logic [19:0] ssd;
  logic [3:0] blink_mask;
  logic blink_rst;
  logic [3:0] dp_mask;
  logic [6:0] seg;
  logic [3:0] an;
  logic dp;
  modport master (output ssd, blink_mask, blink_rst, dp_mask, input seg, an, dp);
  modport slave (input ssd, blink_mask, blink_rst, dp_mask, output seg, an, dp);
endinterface

// File: rtl/binary_to_segment.sv
// binary_to_segment: 5-bit display code to active-low {g,f,e,d,c,b,a} segments
module binary_to_segment
  import ssd_pkg::*;
(
  input  ssd_code_t  code_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = SEG_BLANK;
    case (code_i)
      5'h00: seg_o = 7'b1000000;
      5'h01: seg_o = 7'b1111001;
      5'h02: seg_o = 7'b0100100;
      5'h03: seg_o = 7'b0110000;
      5'h04: seg_o = 7'b0011001;
      5'h05: seg_o = 7'b0010010;
      5'h06: seg_o = 7'b0000010;
      5'h07: seg_o = 7'b1111000;
      5'h08: seg_o = 7'b0000000;
      5'h09: seg_o = 7'b0010000;
      5'h0A: seg_o = 7'b0001000;
      5'h0B: seg_o = 7'b0000011;
      5'h0C: seg_o = 7'b1000110;
      5'h0D: seg_o = 7'b0100001;
      5'h0E: seg_o = 7'b0000110;
      5'h0F: seg_o = 7'b0001110;
      SSD_C: seg_o = 7'b1000110;
      SSD_L: seg_o = 7'b1000111;
      SSD_TIRE: seg_o = 7'b0111111;
      SSD_P: seg_o = 7'b0001100;
      SSD_E: seg_o = 7'b0000110;
      SSD_N: seg_o = 7'b0101011;
      SSD_U: seg_o = 7'b1000001;
      SSD_O: seg_o = 7'b1000000;
      default: seg_o = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/ssd_scan.sv
// ssd_scan: four-digit multiplexed seven-segment driver with per-digit blink; SSD_DP_EN adds decimal points
module ssd_scan
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV = 50000000
) (
  input logic clk,
  input logic rst,
  ssd_scan_if.slave bus
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [1:0] idx_q, idx_d;
  logic phase_q, phase_d;
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d, glyph;
  logic [3:0][4:0] codes;
  ssd_code_t code;
  logic r_tc, b_tc, blank;
  assign codes = bus.ssd;
  assign code = codes[idx_q];
  binary_to_segment u_dec (.code_i(code), .seg_o(glyph));
  // blink_rst wins over the blink terminal count so the phase restarts cleanly
  always_comb begin
    r_tc = rcnt_q == RW'(REFRESH_DIV - 1);
    b_tc = bcnt_q == BW'(BLINK_DIV - 1);
    rcnt_d = r_tc ? '0 : rcnt_q + 1'b1;
    idx_d = r_tc ? idx_q + 2'd1 : idx_q;
    bcnt_d = (bus.blink_rst || b_tc) ? '0 : bcnt_q + 1'b1;
    phase_d = bus.blink_rst ? 1'b1 : phase_q ^ b_tc;
    blank = bus.blink_mask[idx_q] & ~phase_q;
    an_d = ~(4'b1 << idx_q);
    seg_d = blank ? SEG_BLANK : glyph;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      rcnt_q <= '0;
      idx_q <= '0;
      bcnt_q <= '0;
      phase_q <= 1'b1;
      an_q <= 4'b1111;
      seg_q <= SEG_BLANK;
    end else begin
      rcnt_q <= rcnt_d;
      idx_q <= idx_d;
      bcnt_q <= bcnt_d;
      phase_q <= phase_d;
      an_q <= an_d;
      seg_q <= seg_d;
    end
  end
  assign bus.an = an_q;
  assign bus.seg = seg_q;
`ifdef SSD_DP_EN
  logic dp_q;
  always_ff @(posedge clk) begin
    if (!rst) dp_q <= 1'b1;
    else dp_q <= blank | ~bus.dp_mask[idx_q];
  end
  assign bus.dp = dp_q;
`else
  assign bus.dp = 1'b1;
`endif
endmodule

// File: tb/tb_ssd_scan.sv
// tb_ssd_scan: directed checks of scan order, decode, blink phase, blink restart, reset and dp
module tb_ssd_scan;
  import ssd_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  ssd_scan_if bus ();
  ssd_scan #(.REFRESH_DIV(4), .BLINK_DIV(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [3:0] an_of(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << i);
  endfunction
  initial begin
    int i;
    bit vis;
    logic [6:0] ex;
    logic [6:0] t1 [4];
    logic ex_dp;
    t1 = '{7'b0100001, 7'b0010010, 7'b1000111, 7'b1000110};
    bus.ssd = {5'h11, 5'h12, 5'h05, 5'h0D};
    bus.blink_mask = 4'b0000;
    bus.blink_rst = 1'b0;
    bus.dp_mask = 4'b0000;
    step();
    step();
    chk("rst_an", {3'b0, bus.an}, 7'h0F);
    chk("rst_seg", bus.seg, 7'h7F);
    chk("rst_dp", {6'b0, bus.dp}, 7'h01);
    rst = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      chk("scan_an", {3'b0, bus.an}, {3'b0, an_of(k / 4)});
      chk("scan_seg", bus.seg, t1[k / 4]);
    end
    step();
    chk("wrap_an", {3'b0, bus.an}, 7'h0E);
    rst = 1'b0;
    bus.ssd = {5'h08, SSD_BLANK, SSD_BLANK, SSD_BLANK};
    bus.blink_mask = 4'b1000;
    step();
    rst = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      step();
      i = ((k - 1) / 4) % 4;
      vis = ((k - 1) / 16) % 2 == 0;
      ex = (i == 3 && vis) ? 7'h00 : 7'h7F;
      chk("blink_an", {3'b0, bus.an}, {3'b0, an_of(i)});
      chk("blink_seg", bus.seg, ex);
    end
    bus.ssd = {4{5'h08}};
    bus.blink_mask = 4'b1111;
    for (int k = 49; k <= 90; k++) begin
      if (k == 55) bus.blink_rst = 1'b1;
      step();
      bus.blink_rst = 1'b0;
      i = ((k - 1) / 4) % 4;
      vis = k <= 55 ? ((k - 1) / 16) % 2 == 0 : ((k - 56) / 16) % 2 == 0;
      chk("brst_an", {3'b0, bus.an}, {3'b0, an_of(i)});
      chk("brst_seg", bus.seg, vis ? 7'h00 : 7'h7F);
    end
    chk("pre_rst_an", {3'b0, bus.an}, 7'h0B);
    rst = 1'b0;
    step();
    chk("mid_rst_an", {3'b0, bus.an}, 7'h0F);
    chk("mid_rst_seg", bus.seg, 7'h7F);
    chk("mid_rst_dp", {6'b0, bus.dp}, 7'h01);
    rst = 1'b1;
    for (int j = 0; j < 8; j++) begin
      step();
      chk("restart_an", {3'b0, bus.an}, {3'b0, an_of(j / 4)});
      chk("restart_seg", bus.seg, 7'h00);
    end
    bus.blink_mask = 4'b0000;
    bus.dp_mask = 4'b0010;
    for (int j = 8; j < 24; j++) begin
      step();
      i = (j / 4) % 4;
`ifdef SSD_DP_EN
      ex_dp = i != 1;
`else
      ex_dp = 1'b1;
`endif
      chk("dp_an", {3'b0, bus.an}, {3'b0, an_of(i)});
      chk("dp", {6'b0, bus.dp}, {6'b0, ex_dp});
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
